uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO. Replaces the single-byte transmitter in the serial link path. It adds configurable data width, one or two stop bits, optional parity, and a FIFO of depth `FIFO_DEPTH` so that frames go out back-to-back with no idle gap. It sits between the link packetiser (valid/ready source) and the board TX pin.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per character, 5..9.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CLK_FREQ`, 50_000_000: clk frequency in Hz.
- `BAUD_RATE`, 115_200: line rate. `PULSE_WIDTH = CLK_FREQ/BAUD_RATE` (integer divide), required ≥2.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  clock enable; when low, all state (FIFO, FSM, counters, outputs) holds.
- `tx_data`  in  DATA_WIDTH  character to send.
- `tx_valid`  in  1  source has a character.
- `tx_ready`  out  1  FIFO not full and `ena`=1; a push occurs on an edge where `tx_valid & tx_ready`.
- `parity_odd`  in  1  0 = even parity, 1 = odd. Present only with `UART_TX_PARITY_EN`.
- `tx_signal`  out  1  serial line, idle high.
- `tx_busy`  out  1  FSM not in IDLE.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Reset values: `tx_signal`=1, `tx_busy`=0, `fifo_level`=0, FIFO empty, FSM=IDLE, bit counter 0, clock counter 0. `tx_ready` follows `ena` after reset.
- FIFO is first-word-fall-through internally.
  - Push and pop on the same edge leave `fifo_level` unchanged.
  - A push when full is impossible, because `tx_ready` is 0.
  - There is no bypass: `tx_ready` stays 0 when full, even if a pop happens on the same edge.
- FSM states are IDLE, START, DATA, PARITY (macro only) and STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, set `tx_signal`=0, load clock counter with PULSE_WIDTH-1, then go to START.
  - START: when clock counter = 0, drive bit 0 and go to DATA. Otherwise decrement the counter.
  - DATA: bits are sent LSB first, each held for PULSE_WIDTH enabled cycles. After bit DATA_WIDTH-1, go to PARITY if enabled, else STOP.
  - PARITY: drives the XOR of all data bits, XOR `parity_odd`. `parity_odd` is sampled at pop time. Held for PULSE_WIDTH cycles.
  - STOP: `tx_signal`=1 for STOP_BITS×PULSE_WIDTH cycles. At expiry:
    - If the FIFO is non-empty, pop, drive 0 and go directly to START (no idle bit).
    - Otherwise go to IDLE.
- Undefined state encoding: go to IDLE with `tx_signal`=1.
- Reset mid-frame: the frame is aborted, the line returns high on the next edge, and FIFO contents are discarded.

## Timing
- All outputs except `tx_ready` are registered.
- Latency: a push at edge k into an empty FIFO with FSM in IDLE gives `tx_signal`=0 from edge k+1.
- Frame length in enabled cycles: (1 + DATA_WIDTH + P + STOP_BITS)×PULSE_WIDTH, where P = 1 with parity, else 0.
- Every bit lasts exactly PULSE_WIDTH enabled cycles.
- Consecutive frames abut exactly, with no extra cycles.
- `ena` low stretches the bit in progress by the number of disabled cycles; there are no glitches.
- `tx_busy` rises at the edge that leaves IDLE and falls at the edge that enters IDLE.
- Counter widths: clock counter is $clog2(STOP_BITS×PULSE_WIDTH)+1 bits; bit counter is $clog2(DATA_WIDTH)+1 bits. No wrap-around is permitted.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The `parity_odd` port exists.
  - The PARITY state is inserted between DATA and STOP.
- Not defined:
  - No `parity_odd` port.
  - DATA goes straight to STOP.
  - Frame length excludes parity.

## Test plan
Test parameters: CLK_FREQ=1000, BAUD_RATE=100 (PULSE_WIDTH=10), DATA_WIDTH=8, FIFO_DEPTH=4.
- Reset check: hold `reset_n`=0 for 3 cycles → `tx_signal`=1, `tx_busy`=0, `fifo_level`=0, `tx_ready`=1.
- Single frame: push 0xA5, STOP_BITS=1, no parity → line low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles. `tx_busy` high for exactly 100 cycles.
- FIFO fill: push 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back while idle.
  - First character pops at once.
  - `fifo_level` peaks at 3 with 4 accepted, or reaches 4 with `tx_ready`=0 if pushes outpace the pop.
  - All characters go out in order with zero idle cycles between frames.
- Parity, with macro and STOP_BITS=2: send 0x07 with `parity_odd`=0 → parity bit 1, then line high 20 cycles. Send 0x07 with `parity_odd`=1 → parity bit 0.
- Enable stall: drop `ena` for 7 cycles mid-DATA → that bit lasts 17 clk cycles, total frame 107 cycles, and no push is accepted while `ena`=0.
- Reset mid-frame: assert `reset_n`=0 during bit 3 with 2 entries queued → line high on the next edge, `fifo_level`=0, and no further frames after release.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a first-word-fall-through FIFO; queued characters leave back-to-back.
// Optional parity bit and parity_odd input are enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ena,
  input  logic [DATA_WIDTH-1:0]       tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
`ifdef UART_TX_PARITY_EN
  input  logic                        parity_odd,
`endif
  output logic                        tx_signal,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W       = $clog2(STOP_BITS * PULSE_WIDTH) + 1;
  localparam int BIT_W       = $clog2(DATA_WIDTH) + 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int LVL_W       = PTR_W + 1;

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_RELOAD = CNT_W'(STOP_BITS * PULSE_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_WIDTH - 1);
  localparam logic [LVL_W-1:0] FULL_LEVEL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [CNT_W-1:0]      clk_cnt;
  logic [CNT_W-1:0]      clk_cnt_next;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_cnt_next;
  logic                  line_next;
  logic                  start_frame;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit;
  logic                  parity_next;
`endif

  // No bypass path: a full FIFO refuses data even on an edge that also pops.
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LEVEL);
  assign tx_ready   = ena & ~fifo_full;
  assign push       = tx_valid & tx_ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (ena && push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (ena) begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    line_next    = tx_signal;
    start_frame  = 1'b0;
    pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_bit;
`endif

    case (state)
      IDLE: begin
        line_next = 1'b1;
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (clk_cnt == '0) begin
          line_next    = shift[0];
          shift_next   = shift >> 1;
          clk_cnt_next = BIT_RELOAD;
          bit_cnt_next = '0;
          state_next   = DATA;
        end else begin
          clk_cnt_next = clk_cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt == '0) begin
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            line_next    = parity_bit;
            clk_cnt_next = BIT_RELOAD;
            state_next   = PARITY;
`else
            line_next    = 1'b1;
            clk_cnt_next = STOP_RELOAD;
            state_next   = STOP;
`endif
          end else begin
            line_next    = shift[0];
            shift_next   = shift >> 1;
            clk_cnt_next = BIT_RELOAD;
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end else begin
          clk_cnt_next = clk_cnt - CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (clk_cnt == '0) begin
          line_next    = 1'b1;
          clk_cnt_next = STOP_RELOAD;
          state_next   = STOP;
        end else begin
          clk_cnt_next = clk_cnt - CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (clk_cnt == '0) begin
          if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            line_next  = 1'b1;
            state_next = IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt - CNT_W'(1);
        end
      end
      default: begin
        line_next  = 1'b1;
        state_next = IDLE;
      end
    endcase

    // Shared by IDLE and STOP so the next start bit follows the last stop bit with no gap.
    if (start_frame) begin
      pop          = 1'b1;
      shift_next   = head;
      line_next    = 1'b0;
      clk_cnt_next = BIT_RELOAD;
      bit_cnt_next = '0;
      state_next   = START;
`ifdef UART_TX_PARITY_EN
      parity_next  = (^head) ^ parity_odd;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift      <= '0;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      tx_signal  <= 1'b1;
      tx_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (ena) begin
      state      <= state_next;
      shift      <= shift_next;
      clk_cnt    <= clk_cnt_next;
      bit_cnt    <= bit_cnt_next;
      tx_signal  <= line_next;
      tx_busy    <= (state_next != IDLE);
`ifdef UART_TX_PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: table-driven single frames, then FIFO fill, enable stall and
// mid-frame reset sequences; a line decoder pops expected characters from a scoreboard.
module tb_uart_tx_fifo;

  localparam int PW = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P  = 1;
  localparam int SB = 2;
`else
  localparam int P  = 0;
  localparam int SB = 1;
`endif
  localparam int FRAME_LEN = (1 + 8 + P + SB) * PW;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ena;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       par_odd;
  logic       tx_signal;
  logic       tx_busy;
  logic [2:0] fifo_level;

  uart_tx_fifo #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4),
    .CLK_FREQ  (1000),
    .BAUD_RATE (100),
    .STOP_BITS (SB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ena       (ena),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
`ifdef UART_TX_PARITY_EN
    .parity_odd(par_odd),
`endif
    .tx_signal (tx_signal),
    .tx_busy   (tx_busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int sb_q[$];
  int gap_log[$];

  typedef struct {
    logic [7:0] data;
    logic       par_odd;
    logic       exp_par;
    int         exp_cycles;
  } vec_t;

  vec_t vecs[6];
  logic trace[130];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Caller must be between posedge+1 and the next negedge; returns at posedge+1 after the push edge.
  task automatic applyStimulus(input logic [7:0] d, input logic p, input logic exp_p);
    int   waited = 0;
    logic acc    = 1'b0;
    int   e;
    tx_data  = d;
    par_odd  = p;
    tx_valid = 1'b1;
    while (!acc && waited < 1000) begin
      @(negedge clk);
      acc = tx_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    tx_valid = 1'b0;
    if (acc) begin
      e = int'(d);
      if (P == 1) e = e | (int'(exp_p) << 8);
      sb_q.push_back(e);
    end else begin
      checkOutput("push_timeout", 32'(waited), 32'd0);
    end
  endtask

  task automatic sync_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) checkOutput("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  // Decoder counts only enabled cycles, so a correct frame always spans FRAME_LEN samples.
  logic       mon_active = 1'b0;
  int         mon_pos    = 0;
  int         bit_idx    = 0;
  int         idle_run   = 0;
  logic       cur_level  = 1'b1;
  logic       shape_ok   = 1'b1;
  logic [8:0] mon_word   = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_active = 1'b0;
      idle_run   = 0;
    end else if (ena) begin
      if (!mon_active && tx_signal == 1'b0) begin
        mon_active = 1'b1;
        mon_pos    = 0;
        shape_ok   = 1'b1;
        mon_word   = '0;
        gap_log.push_back(idle_run);
        idle_run   = 0;
      end
      if (mon_active) begin
        bit_idx = mon_pos / PW;
        if (mon_pos % PW == 0) begin
          cur_level = tx_signal;
          if (bit_idx >= 1 && bit_idx <= 8 + P) mon_word[bit_idx-1] = tx_signal;
        end else if (tx_signal !== cur_level) begin
          shape_ok = 1'b0;
        end
        if (bit_idx == 0 && tx_signal !== 1'b0) shape_ok = 1'b0;
        if (bit_idx > 8 + P && tx_signal !== 1'b1) shape_ok = 1'b0;
        mon_pos++;
        if (mon_pos == FRAME_LEN) begin
          mon_active = 1'b0;
          if (sb_q.size() == 0) begin
            checkOutput("frame_unexpected", 32'(mon_word), 32'hFFFF_FFFF);
          end else begin
            checkOutput("frame_data", 32'(mon_word), 32'(sb_q.pop_front()));
          end
          checkOutput("frame_shape", 32'(shape_ok), 32'd1);
        end
      end else begin
        idle_run++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc;
    int   base;
    int   busy_cnt;
    int   ready_leak;
    int   run_idx;
    int   run_len;
    int   bit2_len;
    int   bad;
    logic [7:0] d;

    reset_n  = 1'b0;
    ena      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    par_odd  = 1'b0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, FRAME_LEN};
    vecs[1] = '{8'h07, 1'b0, 1'b1, FRAME_LEN};
    vecs[2] = '{8'h07, 1'b1, 1'b0, FRAME_LEN};
    vecs[3] = '{8'h00, 1'b1, 1'b1, FRAME_LEN};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, FRAME_LEN};
    vecs[5] = '{8'h80, 1'b1, 1'b0, FRAME_LEN};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tx_signal", 32'(tx_signal), 32'd1);
    checkOutput("reset_tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("reset_fifo_level", 32'(fifo_level), 32'd0);
    checkOutput("reset_tx_ready", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) sync_drive();

    for (int i = 0; i < 6; i++) begin
      sync_drive();
      applyStimulus(vecs[i].data, vecs[i].par_odd, vecs[i].exp_par);
      @(negedge clk);
      checkOutput("pre_pop_level", 32'(fifo_level), 32'd1);
      checkOutput("pre_pop_line", 32'(tx_signal), 32'd1);
      @(negedge clk);
      checkOutput("start_line", 32'(tx_signal), 32'd0);
      cyc = 0;
      while (tx_busy && cyc < 1000) begin
        cyc++;
        @(negedge clk);
      end
      checkOutput("busy_cycles", 32'(cyc), 32'(vecs[i].exp_cycles));
      wait_drain();
    end

    // Back-to-back pushes outpace the single pop, so the FIFO ends up full.
    sync_drive();
    base = gap_log.size();
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      applyStimulus(d, 1'b0, ^d);
    end
    @(negedge clk);
    checkOutput("fill_level", 32'(fifo_level), 32'd4);
    checkOutput("fill_ready", 32'(tx_ready), 32'd0);
    wait_drain();
    for (int i = 1; i < 5; i++) begin
      if (gap_log.size() > base + i) checkOutput("fill_gap", 32'(gap_log[base+i]), 32'd0);
      else checkOutput("fill_gap_missing", 32'(gap_log.size()), 32'(base + 5));
    end

    // Seven disabled edges inside data bit 2 of 0x55 stretch that bit to 17 cycles.
    sync_drive();
    applyStimulus(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    busy_cnt   = 0;
    ready_leak = 0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      trace[c] = tx_signal;
      if (tx_busy) busy_cnt++;
      if (!ena && tx_ready) ready_leak++;
      @(posedge clk);
      #1;
      ena      = !(c >= 33 && c < 40);
      tx_valid = !ena;
      tx_data  = 8'h99;
    end
    run_idx  = 0;
    run_len  = 1;
    bit2_len = -1;
    for (int c = 1; c < 130; c++) begin
      if (trace[c] == trace[c-1]) begin
        run_len++;
      end else begin
        if (run_idx == 3) bit2_len = run_len;
        run_idx++;
        run_len = 1;
      end
    end
    checkOutput("stall_bit_len", 32'(bit2_len), 32'd17);
    checkOutput("stall_busy", 32'(busy_cnt), 32'(FRAME_LEN + 7));
    checkOutput("stall_ready", 32'(ready_leak), 32'd0);
    checkOutput("stall_level", 32'(fifo_level), 32'd0);
    wait_drain();

    // Reset lands in data bit 3 of 0x11 while two characters wait in the FIFO.
    sync_drive();
    applyStimulus(8'h11, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b0, 1'b0);
    repeat (41) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("midframe_line", 32'(tx_signal), 32'd0);
    checkOutput("midframe_level", 32'(fifo_level), 32'd2);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_line", 32'(tx_signal), 32'd1);
    checkOutput("abort_level", 32'(fifo_level), 32'd0);
    checkOutput("abort_busy", 32'(tx_busy), 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx_signal !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checkOutput("post_reset_quiet", 32'(bad), 32'd0);
    checkOutput("post_reset_level", 32'(fifo_level), 32'd0);

    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
